tpu_result_drain: RTL and testbench
===================================

TPU_RESULT_DRAIN -- requirements
Module: tpu_result_drain

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: result-buffer address width.
REQ-002 Parameter SYSTOLIC_ARRAY_WIDTH (W), default 16: lanes per row.
REQ-003 Parameter DATA_WIDTH_ACCUM, default 32: lane width.
REQ-004 Port clk, input, 1: single clock; all logic on rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port start, input, 1: one-cycle request to begin a drain.
REQ-007 Port base_addr, input, ADDR_WIDTH: first row address; sampled with start.
REQ-008 Port len_rows, input, 8: rows to drain; sampled with start.
REQ-009 Port col_mask, input, W: lane enable; bit j=0 forces lane j output to zero; sampled with start.
REQ-010 Port abort, input, 1: synchronous cancel of the current drain.
REQ-011 Port busy, output, 1: drain in progress.
REQ-012 Port done, output, 1: one-cycle completion pulse.
REQ-013 Port rd_en, output, 1: result-buffer read strobe.
REQ-014 Port rd_addr, output, ADDR_WIDTH: result-buffer read address.
REQ-015 Port rd_data, input, W x DATA_WIDTH_ACCUM signed: read data, valid exactly one cycle after rd_en.
REQ-016 Port out_valid/out_ready, output/input, 1 each: output stream handshake.
REQ-017 Port out_data, output, W x DATA_WIDTH_ACCUM signed: one row per beat.
REQ-018 Port out_last, output, 1: marks final row of a drain.
REQ-019 Port out_row, output, 8: row index (0-based) of current beat.

Function
REQ-020 FSM states IDLE, RUN, FLUSH, DONE.
REQ-021 IDLE: start latches base/len/mask; len_rows=0 -> DONE with no rd_en; else -> RUN.
REQ-022 start while not IDLE is ignored.
REQ-023 RUN: issue rd_en for row i at rd_addr = (base_addr + i) mod 2^ADDR_WIDTH, i ascending; after last issue -> FLUSH.
REQ-024 Read issued only when (FIFO occupancy + reads in flight) < 2; at most one rd_en per cycle.
REQ-025 Returned row written into a 2-entry output FIFO the cycle after rd_en, with col_mask applied.
REQ-026 out_valid = FIFO non-empty; beat transfers when out_valid & out_ready; out_data/out_last/out_row stable while out_valid & !out_ready.
REQ-027 Simultaneous FIFO write and read allowed; with out_ready held 1, throughput is one row per cycle.
REQ-028 FLUSH -> DONE on handshake of the beat with out_last=1.
REQ-029 DONE: done=1 for one cycle, then IDLE; busy=1 in RUN/FLUSH/DONE.
REQ-030 abort in any non-IDLE state: FIFO cleared, in-flight read discarded, no done, IDLE next cycle.
REQ-031 Lane data passes unmodified (no saturation or sign change) except masked lanes = 0.

Reset
REQ-032 rst_n low: state IDLE; busy, done, rd_en, out_valid, out_last = 0; rd_addr, out_row, out_data = 0; FIFO empty; in-flight read discarded.
REQ-033 Reset mid-drain: no done and no further rd_en after release until a new start.

Structure
REQ-034 FSM state enum and default widths live in the shared TPU package alongside the command struct.
REQ-035 The 2-entry output FIFO is a sub-module, drain_fifo2.

Verification
REQ-036 base=0x200, len=4, row i lane j = 16*i+j, mask=0xFFFF, out_ready=1 -> rd_addr 0x200..0x203 on consecutive cycles, 4 beats, out_last on row 3, done one cycle after last handshake.
REQ-037 Same drain, out_ready toggling 1/0 each cycle -> identical data order, no lost or duplicated row, data stable while stalled, never more than 2 reads outstanding.
REQ-038 base=0x3FE, len=4 -> rd_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
REQ-039 len=0 -> done one cycle after start, rd_en never asserted, out_valid never asserted.
REQ-040 mask=0x00FF, all rows 0x00010009 -> lanes 0-7 = 0x00010009, lanes 8-15 = 0.
REQ-041 rst_n low (or abort) after beat 1 of len=8 -> outputs at reset values, no done; a subsequent start with len=2 completes normally.

Source files
------------

// File: rtl/tpu_result_drain_pkg.sv
// Shared types for the TPU result-drain block: FSM state encoding, default
// geometry and the drain command record.
package tpu_result_drain_pkg;

    localparam int DEF_ADDR_WIDTH       = 10;
    localparam int DEF_ARRAY_WIDTH      = 16;
    localparam int DEF_DATA_WIDTH_ACCUM = 32;
    localparam int ROW_IDX_WIDTH        = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_e;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0]  base_addr;
        logic [ROW_IDX_WIDTH-1:0]   len_rows;
        logic [DEF_ARRAY_WIDTH-1:0] col_mask;
    } drain_cmd_t;

endpackage

// File: rtl/drain_fifo2.sv
// Two-entry FIFO for drained rows. A write into a full FIFO is accepted
// only when a read retires an entry in the same cycle.
module drain_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             not_empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt_q;
    logic             do_wr;
    logic             do_rd;

    assign do_rd     = rd_en && (cnt_q != 2'd0);
    assign do_wr     = wr_en && ((cnt_q != 2'd2) || do_rd);
    assign rd_data   = mem[rd_ptr];
    assign not_empty = (cnt_q != 2'd0);
    assign count     = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= 2'd0;
        end else if (clr) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (do_wr) wr_ptr <= ~wr_ptr;
            if (do_rd) rd_ptr <= ~rd_ptr;
            cnt_q <= cnt_q + {1'b0, do_wr} - {1'b0, do_rd};
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !clr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/tpu_result_drain.sv
// Drains rows from the accumulator result buffer into a masked valid/ready
// output stream, one row per beat with row index and last marker.
module tpu_result_drain
    import tpu_result_drain_pkg::*;
#(
    parameter int ADDR_WIDTH           = DEF_ADDR_WIDTH,
    parameter int SYSTOLIC_ARRAY_WIDTH = DEF_ARRAY_WIDTH,
    parameter int DATA_WIDTH_ACCUM     = DEF_DATA_WIDTH_ACCUM
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic                                                    start,
    input  logic [ADDR_WIDTH-1:0]                                   base_addr,
    input  logic [7:0]                                              len_rows,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]                         col_mask,
    input  logic                                                    abort,
    output logic                                                    busy,
    output logic                                                    done,
    output logic                                                    rd_en,
    output logic [ADDR_WIDTH-1:0]                                   rd_addr,
    input  logic signed [SYSTOLIC_ARRAY_WIDTH-1:0][DATA_WIDTH_ACCUM-1:0] rd_data,
    output logic                                                    out_valid,
    input  logic                                                    out_ready,
    output logic signed [SYSTOLIC_ARRAY_WIDTH-1:0][DATA_WIDTH_ACCUM-1:0] out_data,
    output logic                                                    out_last,
    output logic [7:0]                                              out_row,
    output drain_state_e                                            dbg_state
);

    localparam int W  = SYSTOLIC_ARRAY_WIDTH;
    localparam int RW = SYSTOLIC_ARRAY_WIDTH * DATA_WIDTH_ACCUM;
    localparam int FW = RW + 1 + 8;

    drain_state_e              state_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [7:0]                len_q;
    logic [W-1:0]              mask_q;
    logic [7:0]                issue_cnt_q;
    logic                      inflight_q;
    logic [7:0]                inflight_row_q;
    logic                      busy_q;
    logic                      done_q;

    logic                      abort_act;
    logic                      pop;
    logic                      can_issue;
    logic [2:0]                pending;
    logic [1:0]                fifo_count;
    logic [FW-1:0]             fifo_wdata;
    logic [FW-1:0]             fifo_rdata;
    logic [W-1:0][DATA_WIDTH_ACCUM-1:0] masked;

    // Handshake: a beat moves on a cycle where out_valid && out_ready; the
    // head entry is held unchanged until that happens.
    assign abort_act = abort && (state_q != ST_IDLE);
    assign pop       = out_valid && out_ready;

    // Occupancy after this cycle's pop plus the read landing this cycle must
    // leave room for the read issued now, which lands two cycles later.
    assign pending   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign can_issue = (pending < 3'd2);
    assign rd_en     = (state_q == ST_RUN) && !abort && can_issue;
    assign rd_addr   = addr_q;

    always_comb begin
        masked = '0;
        for (int j = 0; j < W; j++) begin
            if (mask_q[j]) masked[j] = rd_data[j];
        end
    end

    assign fifo_wdata = {(inflight_row_q == len_q - 8'd1), inflight_row_q, masked};

    drain_fifo2 #(.WIDTH(FW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (abort_act),
        .wr_en     (inflight_q && !abort_act),
        .wr_data   (fifo_wdata),
        .rd_en     (pop),
        .rd_data   (fifo_rdata),
        .not_empty (out_valid),
        .count     (fifo_count)
    );

    assign out_data  = out_valid ? fifo_rdata[RW-1:0] : '0;
    assign out_row   = out_valid ? fifo_rdata[RW +: 8] : 8'd0;
    assign out_last  = out_valid && fifo_rdata[FW-1];
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            len_q          <= 8'd0;
            mask_q         <= '0;
            issue_cnt_q    <= 8'd0;
            inflight_q     <= 1'b0;
            inflight_row_q <= 8'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else if (abort_act) begin
            state_q    <= ST_IDLE;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inflight_q <= rd_en;
            if (rd_en) inflight_row_q <= issue_cnt_q;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q      <= base_addr;
                        len_q       <= len_rows;
                        mask_q      <= col_mask;
                        issue_cnt_q <= 8'd0;
                        busy_q      <= 1'b1;
                        if (len_rows == 8'd0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (rd_en) begin
                        addr_q      <= addr_q + ADDR_WIDTH'(1);
                        issue_cnt_q <= issue_cnt_q + 8'd1;
                        if (issue_cnt_q == len_q - 8'd1) state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (pop && out_last) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_result_drain.sv
// Randomized scoreboard bench for tpu_result_drain: a result-buffer model
// answers reads, expected rows are queued per drain and checked by a monitor.
module tb_tpu_result_drain;
    import tpu_result_drain_pkg::*;

    localparam int AW = 10;
    localparam int W  = 16;
    localparam int DW = 32;
    localparam int RW = W * DW;
    localparam int EW = RW + 9;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          start = 1'b0;
    logic [AW-1:0]                 base_addr = '0;
    logic [7:0]                    len_rows = 8'd0;
    logic [W-1:0]                  col_mask = '0;
    logic                          abort = 1'b0;
    logic                          busy;
    logic                          done;
    logic                          rd_en;
    logic [AW-1:0]                 rd_addr;
    logic signed [W-1:0][DW-1:0]   rd_data = '0;
    logic                          out_valid;
    logic                          out_ready = 1'b0;
    logic signed [W-1:0][DW-1:0]   out_data;
    logic                          out_last;
    logic [7:0]                    out_row;
    drain_state_e                  dbg_state;

    logic [W-1:0][DW-1:0] mem [1 << AW];
    logic [EW-1:0]        exp_q [$];
    int                   addr_q [$];

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int n_rd = 0, n_beat = 0, n_done = 0, drop_bias = 0;
    int first_rd = -1, last_rd = -1, last_hs_cyc = 0, done_cyc = 0;
    int ready_mode = 0;
    bit ready_hold = 1'b0;

    tpu_result_drain u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len_rows  (len_rows),
        .col_mask  (col_mask),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_row   (out_row),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Result buffer: data appears the cycle after the read strobe.
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got unexpected event expected none", name);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [EW-1:0] exp_row(input int base, input int i, input int len,
                                              input logic [W-1:0] mask);
        logic [W-1:0][DW-1:0] d;
        logic [W-1:0][DW-1:0] m;
        d = mem[(base + i) % (1 << AW)];
        m = '0;
        for (int j = 0; j < W; j++) if (mask[j]) m[j] = d[j];
        return {(i == len - 1), 8'(i), m};
    endfunction

    task automatic monitor();
        logic [EW-1:0] prev = '0;
        logic [EW-1:0] cur;
        logic [EW-1:0] e;
        bit prev_stall = 1'b0;
        bit prev_abort = 1'b0;
        forever begin
            @(negedge clk);
            cur = {out_last, out_row, out_data};
            if (rst_n) begin
                if (prev_stall && !prev_abort) begin
                    check("stall_valid_held", {{(EW-1){1'b0}}, out_valid}, 1);
                    check("stall_beat_stable", cur, prev);
                end
                if (rd_en) begin
                    n_rd++;
                    if (first_rd < 0) first_rd = cyc;
                    last_rd = cyc;
                    if (addr_q.size() == 0) fail("rd_en_unexpected");
                    else check_int("rd_addr", int'(rd_addr), addr_q.pop_front());
                end
                if (out_valid && out_ready) begin
                    n_beat++;
                    if (exp_q.size() == 0) fail("beat_unexpected");
                    else begin
                        e = exp_q.pop_front();
                        check("beat", cur, e);
                    end
                    if (out_last) last_hs_cyc = cyc;
                end
                if (rd_en) check_int("outstanding_le2", int'((n_rd - n_beat - drop_bias) <= 2), 1);
                if (done) begin
                    n_done++;
                    done_cyc = cyc;
                end
            end
            prev_stall = rst_n && out_valid && !out_ready;
            prev_abort = abort;
            prev = cur;
        end
    endtask

    task automatic ready_drv();
        forever begin
            @(posedge clk);
            #1;
            if (ready_hold) out_ready = 1'b0;
            else if (ready_mode == 0) out_ready = 1'b1;
            else if (ready_mode == 1) out_ready = ~out_ready;
            else out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic queue_cmd(input drain_cmd_t c);
        for (int i = 0; i < int'(c.len_rows); i++) begin
            exp_q.push_back(exp_row(int'(c.base_addr), i, int'(c.len_rows), c.col_mask));
            addr_q.push_back((int'(c.base_addr) + i) % (1 << AW));
        end
    endtask

    task automatic do_drain(input drain_cmd_t c, input int mode, input bit poke, input bit chk_tp);
        int t0, d0, r0, b0, bound;
        ready_mode = mode;
        first_rd = -1;
        d0 = n_done;
        r0 = n_rd;
        b0 = n_beat;
        queue_cmd(c);
        step();
        start = 1'b1;
        base_addr = c.base_addr;
        len_rows = c.len_rows;
        col_mask = c.col_mask;
        t0 = cyc;
        step();
        start = 1'b0;
        bound = 0;
        while (n_done == d0 && bound < 3000) begin
            if (poke && bound == 2) begin
                start = 1'b1;
                base_addr = ~c.base_addr;
                len_rows = 8'd5;
                col_mask = ~c.col_mask;
            end else begin
                start = 1'b0;
            end
            step();
            bound++;
        end
        start = 1'b0;
        if (n_done == d0) begin
            fail("done_timeout");
            exp_q.delete();
            addr_q.delete();
            drop_bias = n_rd - n_beat;
        end else begin
            if (c.len_rows == 8'd0) check_int("done_lat_len0", done_cyc - t0, 1);
            else check_int("done_after_last", done_cyc - last_hs_cyc, 1);
            repeat (3) step();
            check_int("done_once", n_done - d0, 1);
            check_int("busy_after", int'(busy), 0);
            check_int("rows_left", exp_q.size(), 0);
            check_int("addr_left", addr_q.size(), 0);
            check_int("rd_count", n_rd - r0, int'(c.len_rows));
            check_int("beat_count", n_beat - b0, int'(c.len_rows));
            if (chk_tp) check_int("rd_consecutive", last_rd - first_rd, int'(c.len_rows) - 1);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_int({tag, "_busy"}, int'(busy), 0);
        check_int({tag, "_done"}, int'(done), 0);
        check_int({tag, "_rd_en"}, int'(rd_en), 0);
        check_int({tag, "_out_valid"}, int'(out_valid), 0);
        check_int({tag, "_out_last"}, int'(out_last), 0);
        check_int({tag, "_out_row"}, int'(out_row), 0);
        check({tag, "_out_data"}, EW'(out_data), '0);
    endtask

    task automatic cut_drain(input bit use_rst);
        drain_cmd_t c;
        int b0, d0, r0, bound;
        c.base_addr = 10'h100;
        c.len_rows = 8'd8;
        c.col_mask = 16'($urandom);
        ready_mode = 0;
        b0 = n_beat;
        queue_cmd(c);
        step();
        start = 1'b1;
        base_addr = c.base_addr;
        len_rows = c.len_rows;
        col_mask = c.col_mask;
        step();
        start = 1'b0;
        bound = 0;
        while (n_beat == b0 && bound < 200) begin
            step();
            bound++;
        end
        if (n_beat == b0) fail("first_beat_timeout");
        ready_hold = 1'b1;
        step();
        if (use_rst) begin
            rst_n = 1'b0;
            #1;
            check_idle_outputs("rst_mid");
            check_int("rst_mid_rd_addr", int'(rd_addr), 0);
            exp_q.delete();
            addr_q.delete();
            drop_bias = n_rd - n_beat;
            step();
            step();
            rst_n = 1'b1;
        end else begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            exp_q.delete();
            addr_q.delete();
            drop_bias = n_rd - n_beat;
            check_idle_outputs("abort");
        end
        d0 = n_done;
        r0 = n_rd;
        repeat (10) step();
        check_int("cut_no_done", n_done - d0, 0);
        check_int("cut_no_rd", n_rd - r0, 0);
        check_int("cut_no_beats", n_beat, n_beat + exp_q.size());
        ready_hold = 1'b0;
        c.base_addr = 10'h2F0;
        c.len_rows = 8'd2;
        c.col_mask = 16'hFFFF;
        do_drain(c, 0, 1'b0, 1'b1);
    endtask

    initial begin
        drain_cmd_t c;
        for (int a = 0; a < (1 << AW); a++)
            for (int j = 0; j < W; j++) mem[a][j] = $urandom;
        fork
            monitor();
            ready_drv();
        join_none

        #3;
        check_idle_outputs("reset");
        check_int("reset_rd_addr", int'(rd_addr), 0);
        check_int("reset_state", int'(dbg_state), int'(ST_IDLE));
        step();
        step();
        rst_n = 1'b1;
        step();

        // Ramp rows at 0x200, full-rate then stalled every other cycle.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < W; j++) mem[10'h200 + i][j] = 32'(16 * i + j);
        c = '{base_addr: 10'h200, len_rows: 8'd4, col_mask: 16'hFFFF};
        do_drain(c, 0, 1'b0, 1'b1);
        do_drain(c, 1, 1'b1, 1'b0);

        c = '{base_addr: 10'h3FE, len_rows: 8'd4, col_mask: 16'hFFFF};
        do_drain(c, 0, 1'b1, 1'b1);

        c = '{base_addr: 10'h123, len_rows: 8'd0, col_mask: 16'hFFFF};
        do_drain(c, 0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++)
            for (int j = 0; j < W; j++) mem[10'h050 + i][j] = 32'h0001_0009;
        c = '{base_addr: 10'h050, len_rows: 8'd3, col_mask: 16'h00FF};
        do_drain(c, 2, 1'b0, 1'b0);

        cut_drain(1'b1);
        cut_drain(1'b0);

        for (int k = 0; k < 12; k++) begin
            c.base_addr = 10'($urandom_range(0, 1023));
            c.len_rows = 8'($urandom_range(0, 12));
            c.col_mask = 16'($urandom);
            do_drain(c, $urandom_range(0, 2), c.len_rows >= 8'd4, 1'b0);
        end

        c = '{base_addr: 10'h3F8, len_rows: 8'd20, col_mask: 16'hA5C3};
        do_drain(c, 0, 1'b0, 1'b1);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
